// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register with operand forwarding and ALU-control decode.
// Presents registered a/b/binvert/carryin/op to the ALU behind a valid/ready handshake.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  rs_num,
    input  logic [REG_W-1:0]  rt_num,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic [1:0]        alu_ctl,
    input  logic [5:0]        funct,
    input  logic [REG_W-1:0]  dest_in,
    input  logic              wr_in,
    input  logic              exm_wr,
    input  logic [REG_W-1:0]  exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              mwb_wr,
    input  logic [REG_W-1:0]  mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              binvert,
    output logic              carryin,
    output logic [1:0]        alu_op,
    output logic [REG_W-1:0]  dest_out,
    output logic              wr_out,
    output logic              illegal
);
    logic              load;
    logic              r_type, is_add, is_sub, is_and, is_or, bad;
    logic [1:0]        op_d;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    assign in_ready = !stall && (!out_valid || out_ready);
    assign load     = in_valid && in_ready;

    // EX/MEM is the younger result, so it is checked first; r0 is never forwarded
    assign fwd_rs = (exm_wr && exm_rd == rs_num && rs_num != '0) ? exm_data :
                    (mwb_wr && mwb_rd == rs_num && rs_num != '0) ? mwb_data : rs_data;
    assign fwd_rt = (exm_wr && exm_rd == rt_num && rt_num != '0) ? exm_data :
                    (mwb_wr && mwb_rd == rt_num && rt_num != '0) ? mwb_data : rt_data;

    assign r_type = alu_ctl == 2'b10;
    assign is_add = alu_ctl == 2'b00 || (r_type && funct == 6'b100000);
    assign is_sub = alu_ctl == 2'b01 || (r_type && funct == 6'b100010);
    assign is_and = r_type && funct == 6'b100100;
    assign is_or  = r_type && funct == 6'b100101;
    assign bad    = !(is_add || is_sub || is_and || is_or);
    assign op_d   = (is_add || is_sub) ? 2'b10 : is_and ? 2'b00 : is_or ? 2'b01 : 2'b11;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            binvert   <= 1'b0;
            carryin   <= 1'b0;
            alu_op    <= 2'b11;
            dest_out  <= '0;
            wr_out    <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            wr_out    <= 1'b0;
            illegal   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            alu_a     <= fwd_rs;
            alu_b     <= alu_src ? imm : fwd_rt;
            binvert   <= is_sub;
            carryin   <= is_sub;
            alu_op    <= op_d;
            dest_out  <= dest_in;
            wr_out    <= wr_in && !bad;
            illegal   <= bad;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with hand-computed expectations for alu_issue_stage.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  rs_num, rt_num, dest_in, exm_rd, mwb_rd, dest_out;
    logic [31:0] rs_data, rt_data, imm, exm_data, mwb_data, alu_a, alu_b;
    logic        alu_src, wr_in, exm_wr, mwb_wr, stall, flush;
    logic [1:0]  alu_ctl, alu_op;
    logic [5:0]  funct;
    logic        out_valid, out_ready, binvert, carryin, wr_out, illegal;
    int          vectors = 0;
    int          miscompares = 0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs_data), .rt_data(rt_data),
        .imm(imm), .alu_src(alu_src), .alu_ctl(alu_ctl), .funct(funct),
        .dest_in(dest_in), .wr_in(wr_in),
        .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .binvert(binvert), .carryin(carryin),
        .alu_op(alu_op), .dest_out(dest_out), .wr_out(wr_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; rs_num = 0; rt_num = 0; rs_data = 0; rt_data = 0;
        imm = 0; alu_src = 0; alu_ctl = 0; funct = 0; dest_in = 0; wr_in = 0;
        exm_wr = 0; exm_rd = 0; exm_data = 0; mwb_wr = 0; mwb_rd = 0; mwb_data = 0;
        stall = 0; flush = 0; out_ready = 0;
        repeat (2) step();
        check("rst_valid", out_valid, 0);
        check("rst_op", alu_op, 2'b11);
        rst_n = 1;

        // R-type sub, no forwarding match
        in_valid = 1; alu_ctl = 2'b10; funct = 6'b100010; rs_num = 1; rt_num = 2;
        rs_data = 32'hA; rt_data = 32'h3; dest_in = 3; wr_in = 1;
        #1 check("sub_in_ready", in_ready, 1);
        step();
        check("sub_valid", out_valid, 1);
        check("sub_a", alu_a, 32'hA);
        check("sub_b", alu_b, 32'h3);
        check("sub_binv", binvert, 1);
        check("sub_cin", carryin, 1);
        check("sub_op", alu_op, 2'b10);
        check("sub_wr", wr_out, 1);
        check("sub_dest", dest_out, 3);
        check("sub_ill", illegal, 0);

        // backpressure with a pending add-immediate that also tests forward priority
        alu_ctl = 2'b00; funct = 0; rs_num = 5; rs_data = 32'h99; alu_src = 1;
        imm = 32'hFFFF_FFFC; exm_wr = 1; exm_rd = 5; exm_data = 32'h11;
        mwb_wr = 1; mwb_rd = 5; mwb_data = 32'h22; dest_in = 7;
        #1 check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", out_valid, 1);
            check("bp_a_hold", alu_a, 32'hA);
            check("bp_op_hold", alu_op, 2'b10);
        end
        out_ready = 1;
        #1 check("bp_release_ready", in_ready, 1);
        step();
        check("b2b_valid", out_valid, 1);
        check("fwd_prio_a", alu_a, 32'h11);
        check("imm_b", alu_b, 32'hFFFF_FFFC);
        check("imm_op", alu_op, 2'b10);
        check("imm_binv", binvert, 0);
        check("imm_dest", dest_out, 7);

        // r0 never forwarded
        rs_num = 0; exm_rd = 0; mwb_rd = 0; rs_data = 32'h77;
        rt_num = 4; rt_data = 32'h44; alu_src = 0;
        step();
        check("r0_a", alu_a, 32'h77);
        check("r0_b", alu_b, 32'h44);

        // MEM/WB-only forward on rs, EX/MEM forward on rt, AND op
        rs_num = 6; exm_rd = 4; mwb_rd = 6; alu_ctl = 2'b10; funct = 6'b100100;
        step();
        check("mwb_a", alu_a, 32'h22);
        check("exm_b", alu_b, 32'h11);
        check("and_op", alu_op, 2'b00);
        check("and_cin", carryin, 0);

        // consume without new load
        in_valid = 0;
        step();
        check("drain_valid", out_valid, 0);
        check("drain_a_hold", alu_a, 32'h22);

        // stall blocks load
        stall = 1; in_valid = 1; funct = 6'b100101;
        #1 check("stall_ready", in_ready, 0);
        step();
        check("stall_valid", out_valid, 0);

        // load once so wr_out is 1, then flush with a simultaneous load
        stall = 0;
        step();
        check("or_op", alu_op, 2'b01);
        check("or_wr", wr_out, 1);
        flush = 1; funct = 6'b100000;
        #1 check("flush_ready", in_ready, 1);
        step();
        check("flush_valid", out_valid, 0);
        check("flush_wr", wr_out, 0);
        flush = 0;

        // illegal funct
        funct = 6'b101010; wr_in = 1;
        step();
        check("ill_valid", out_valid, 1);
        check("ill_flag", illegal, 1);
        check("ill_op", alu_op, 2'b11);
        check("ill_wr", wr_out, 0);

        // reserved alu_ctl
        alu_ctl = 2'b11; funct = 6'b100000;
        step();
        check("rsv_ill", illegal, 1);
        check("rsv_op", alu_op, 2'b11);

        // sub via alu_ctl 01 then async reset mid-cycle
        alu_ctl = 2'b01; rs_num = 1; rs_data = 32'h5; rt_num = 2; rt_data = 32'h9;
        step();
        check("beq_binv", binvert, 1);
        check("beq_ill", illegal, 0);
        check("beq_wr", wr_out, 1);
        in_valid = 0; out_ready = 0;
        #2 rst_n = 0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_wr", wr_out, 0);
        check("arst_a", alu_a, 0);
        check("arst_b", alu_b, 0);
        check("arst_binv", binvert, 0);
        check("arst_cin", carryin, 0);
        check("arst_op", alu_op, 2'b11);
        rst_n = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline register plus ALU-control decode and operand forwarding.
- Sits directly upstream of the 32-bit ALU: it latches one decoded instruction and presents the ALU with a, b, Binvert, Carryin and Op from a register.
- Uses a valid/ready handshake on both sides, with stall and flush, so the ALU input is always registered and stable.

Parameters:
- DATA_W, 32, operand width; must match ALU width.
- REG_W, 5, register-number width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- rs_num, rt_num  in  REG_W  source register numbers.
- rs_data, rt_data  in  DATA_W  register-file read data.
- imm  in  DATA_W  sign-extended immediate.
- alu_src  in  1  1 = B operand is imm, 0 = B operand is forwarded rt.
- alu_ctl  in  2  00 = add (lw/sw), 01 = sub (beq), 10 = R-type (use funct), 11 = reserved.
- funct  in  6  R-type function field.
- dest_in  in  REG_W  destination register.
- wr_in  in  1  instruction writes a register.
- exm_wr, exm_rd, exm_data  in  1/REG_W/DATA_W  EX/MEM forwarding source.
- mwb_wr, mwb_rd, mwb_data  in  1/REG_W/DATA_W  MEM/WB forwarding source.
- stall  in  1  hazard unit holds decode.
- flush  in  1  kill the held instruction.
- out_valid  out  1  ALU inputs hold a live instruction.
- out_ready  in  1  downstream consumes this cycle.
- alu_a, alu_b  out  DATA_W  drive ALU a and b.
- binvert, carryin  out  1  drive ALU Binvert and Carryin.
- alu_op  out  2  drives ALU Op.
- dest_out  out  REG_W  destination register.
- wr_out  out  1  register write enable.
- illegal  out  1  unsupported alu_ctl/funct.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; alu_op = 2'b11 (ALU result 0); out_valid = 0.
- Reset mid-operation discards the held instruction immediately.
- in_ready = !stall && (!out_valid || out_ready). It is combinational and does not depend on in_valid.
- Load occurs on a clock edge when in_valid && in_ready. All output registers update together, and out_valid becomes 1 on the following cycle (latency 1).
- Consume without new load: when out_valid && out_ready && !(in_valid && in_ready), out_valid becomes 0. Data registers hold their values.
- Hold: when out_valid && !out_ready, every output is held unchanged.
- Stall blocks loading only. Downstream may still drain the stage while stalled.
- flush has highest priority:
  - out_valid becomes 0 next edge, wr_out becomes 0 and illegal becomes 0.
  - Any simultaneous load is dropped.
  - Other data registers are don't-care.
- Forwarding (combinational, sampled at load), for each source X in {rs, rt}:
  - If exm_wr && exm_rd == X_num && X_num != 0, use exm_data.
  - Else if mwb_wr && mwb_rd == X_num && X_num != 0, use mwb_data.
  - Else use X_data.
  - EX/MEM wins when both sources match.
- Operand selection: alu_a = forwarded rs; alu_b = alu_src ? imm : forwarded rt.
- ALU-control decode at load, as {binvert, carryin, alu_op}:
  - alu_ctl 00: 0, 0, 10 (add).
  - alu_ctl 01: 1, 1, 10 (a + ~b + 1, i.e. subtract).
  - alu_ctl 10, funct 100000 (add): 0, 0, 10.
  - alu_ctl 10, funct 100010 (sub): 1, 1, 10.
  - alu_ctl 10, funct 100100 (and): 0, 0, 00.
  - alu_ctl 10, funct 100101 (or): 0, 0, 01.
  - Any other funct, or alu_ctl 11: 0, 0, 11; illegal = 1; wr_out forced 0.
- Otherwise wr_out = wr_in and dest_out = dest_in.
- Register number 0 is never forwarded. The value read for r0 passes through unchanged.
- Back-to-back loads: when out_valid && out_ready && in_valid, the new instruction replaces the old one with no bubble.

Test Plan:
- Reset: assert rst_n low mid-cycle with out_valid = 1 -> out_valid, wr_out, alu_a, alu_b, binvert and carryin read 0, and alu_op reads 11, with no clock edge needed.
- R-type sub: alu_ctl 10, funct 100010, rs_data 0x0000000A, rt_data 0x00000003, no forwarding matches -> one cycle later out_valid = 1, alu_a = 0xA, alu_b = 0x3, binvert = 1, carryin = 1, alu_op = 10.
- Forward priority: rs_num = 5, exm_wr = 1, exm_rd = 5, exm_data = 0x11, mwb_wr = 1, mwb_rd = 5, mwb_data = 0x22 -> alu_a = 0x11. Repeat with rs_num = 0 and both sources naming r0 -> alu_a = rs_data.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles with a new in_valid -> in_ready = 0 and outputs unchanged. Then out_ready = 1 -> new instruction loads the same edge and out_valid stays 1.
- Stall/flush: stall = 1 with in_valid = 1 -> in_ready = 0 and no load. flush = 1 together with a load -> out_valid = 0 and wr_out = 0 next cycle.
- Illegal: alu_ctl 10, funct 101010, wr_in = 1 -> illegal = 1, alu_op = 11, wr_out = 0. Immediate path: alu_ctl 00, alu_src = 1, imm 0xFFFFFFFC -> alu_b = 0xFFFFFFFC, alu_op = 10, binvert = 0.
